// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the
// system ID slave.
interface sysid_checker_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (output address, read, input waitrequest, readdata);
    modport slave  (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/sysid_checker.sv
// Reads sysid words 0 (ID) and 1 (timestamp), compares them with build-time
// constants and reports pass/fail. Optional read watchdog: SYSID_CHECKER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | out of reset, waiting for auto-start or start
// RD_ID  | read strobe on word 0 until accepted
// LAT_ID | waiting READ_LATENCY cycles for word 0 data
// RD_TS  | read strobe on word 1 until accepted
// LAT_TS | waiting READ_LATENCY cycles for word 1 data
// DONE   | results valid, waiting for start
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h23176147,
    parameter logic [31:0] EXPECTED_TS    = 32'h52052AC3,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    sysid_checker_if.master avm,
    output logic            busy,
    output logic            done,
    output logic            id_ok,
    output logic            ts_ok,
    output logic            pass,
    output logic            timeout,
    output logic [31:0]     id_value,
    output logic [31:0]     ts_value
);

    typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE} state_t;

    // Latency down-counter reloads on acceptance; terminal count marks the data cycle.
    localparam logic [1:0] LAT_LOAD = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

    state_t     state;
    state_t     state_nxt;
    logic       auto_pend;
    logic [1:0] lat_cnt;
    logic       in_rd;
    logic       accept;
    logic       lat_last;
    logic       stall_hit;
    logic       cap_id;
    logic       cap_ts;
    logic       id_seen;
    logic       start_chk;
    logic       enter_done;

    assign in_rd      = (state == RD_ID) || (state == RD_TS);
    assign accept     = in_rd && !avm.waitrequest;
    assign lat_last   = (lat_cnt == 2'd0);
    assign cap_id     = (state == RD_ID && accept && READ_LATENCY == 0) || (state == LAT_ID && lat_last);
    assign cap_ts     = (state == RD_TS && accept && READ_LATENCY == 0) || (state == LAT_TS && lat_last);
    assign id_seen    = (state == RD_TS) || (state == LAT_TS);
    assign start_chk  = (state_nxt == RD_ID) && (state != RD_ID);
    assign enter_done = (state_nxt == DONE) && (state != DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start || auto_pend) state_nxt = RD_ID;
            RD_ID: begin
                if (stall_hit)   state_nxt = DONE;
                else if (accept) state_nxt = (READ_LATENCY == 0) ? RD_TS : LAT_ID;
            end
            LAT_ID:  if (lat_last) state_nxt = RD_TS;
            RD_TS: begin
                if (stall_hit)   state_nxt = DONE;
                else if (accept) state_nxt = (READ_LATENCY == 0) ? DONE : LAT_TS;
            end
            LAT_TS:  if (lat_last) state_nxt = DONE;
            DONE:    if (start) state_nxt = RD_ID;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        avm.read    = 1'b0;
        avm.address = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            RD_ID: begin
                avm.read = 1'b1;
                busy     = 1'b1;
            end
            LAT_ID:  busy = 1'b1;
            RD_TS: begin
                avm.read    = 1'b1;
                avm.address = 1'b1;
                busy        = 1'b1;
            end
            LAT_TS:  busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        pass = done & id_ok & ts_ok & ~timeout;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend <= AUTO_START;
            lat_cnt   <= LAT_LOAD;
            id_value  <= '0;
            ts_value  <= '0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
        end else begin
            auto_pend <= 1'b0;
            if (accept) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == LAT_ID || state == LAT_TS) && !lat_last) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            if (start_chk) begin
                id_value <= '0;
                ts_value <= '0;
                id_ok    <= 1'b0;
                ts_ok    <= 1'b0;
            end else begin
                if (cap_id) id_value <= avm.readdata;
                if (cap_ts) ts_value <= avm.readdata;
                // Word 1 is compared straight off the bus since it lands on the same edge.
                if (enter_done) begin
                    id_ok <= id_seen && (id_value == EXPECTED_ID);
                    ts_ok <= cap_ts && (avm.readdata == EXPECTED_TS);
                end
            end
        end
    end

`ifdef SYSID_CHECKER_TIMEOUT_EN
    localparam logic [15:0] STALL_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt;

    assign stall_hit = in_rd && avm.waitrequest && (stall_cnt == 16'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= STALL_LOAD;
            timeout   <= 1'b0;
        end else begin
            if (in_rd && avm.waitrequest && !stall_hit) begin
                stall_cnt <= stall_cnt - 16'd1;
            end else begin
                stall_cnt <= STALL_LOAD;
            end
            if (start_chk)      timeout <= 1'b0;
            else if (stall_hit) timeout <= 1'b1;
        end
    end
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign stall_hit      = 1'b0;
    assign timeout        = 1'b0;
`endif

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM master that sequences reads of the system ID slave (word 0 = system ID, word 1 = generation timestamp) after reset or on request. Compares both words against compiled-in expected values and publishes pass/fail status. Sits between the boot/reset logic and the sysid control slave, so the hardware can refuse to release the CPU or raise an LED when the FPGA image does not match the software build.

## Interface

**Parameters**
- `EXPECTED_ID`, default `32'h23176147`: expected word 0.
- `EXPECTED_TS`, default `32'h52052AC3`: expected word 1.
- `READ_LATENCY`, default 1: cycles from read acceptance to valid `avm_readdata`. Legal range 0..3.
- `AUTO_START`, default 1: when 1, a check runs automatically after reset release.
- `TIMEOUT_CYCLES`, default 255: maximum stall cycles per read. Used only with the timeout feature; legal range 1..65535.

**Ports**
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to (re)run a check.
- `avm_address` out 1: word select (0 = ID, 1 = timestamp).
- `avm_read` out 1: read strobe.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdata` in 32: read data.
- `busy` out 1: check in progress.
- `done` out 1: check finished; holds until the next check starts.
- `id_ok` out 1: captured ID equals `EXPECTED_ID`. Valid when `done`.
- `ts_ok` out 1: captured timestamp equals `EXPECTED_TS`. Valid when `done`.
- `pass` out 1: `done & id_ok & ts_ok & ~timeout`.
- `timeout` out 1: a read stalled beyond `TIMEOUT_CYCLES`.
- `id_value` out 32: captured word 0.
- `ts_value` out 32: captured word 1.

## Operation

**States:** IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.

- **IDLE:**
  - Go to RD_ID on `start`, or in the first cycle after reset release when `AUTO_START`=1.
  - On entering RD_ID: clear `done`, `id_ok`, `ts_ok`, `timeout`, `id_value`, `ts_value`.
- **RD_ID:**
  - Drive `avm_read`=1 and `avm_address`=0.
  - The read is accepted in the first cycle where `avm_waitrequest`=0.
  - With `READ_LATENCY`=0, capture `avm_readdata` into `id_value` in the acceptance cycle and go to RD_TS.
  - Otherwise go to LAT_ID.
- **LAT_ID:**
  - `avm_read`=0.
  - Count `READ_LATENCY` cycles after acceptance, capture `id_value` in the last cycle, then go to RD_TS.
- **RD_TS / LAT_TS:** same as RD_ID / LAT_ID with `avm_address`=1 and capture into `ts_value`. Then go to DONE.
- **DONE:**
  - `done`=1, and `id_ok`/`ts_ok` are registered compare results.
  - On `start`, go to RD_ID (clearing status as above).
- **Rules:**
  - `busy`=1 in RD_ID, LAT_ID, RD_TS and LAT_TS.
  - `start` while busy is ignored (no restart, no queuing).
  - `avm_address` and `avm_read` stay stable while `avm_waitrequest`=1.
  - `avm_address` is 0 outside the RD_* states.
  - Comparison is a full 32-bit equality; there is no masking.

## Timing

- **Reset value of every output:** `avm_read`=0, `avm_address`=0, all status outputs 0, `id_value`=`ts_value`=0, state IDLE.
- **Auto-start:** with `AUTO_START`=1, `avm_read` rises in cycle 1 after `reset_n` deasserts.
- **Start latency:** `start` sampled in cycle N gives `avm_read`=1 in cycle N+1.
- **Total latency (zero wait states):** start to `done` is 2×(1+`READ_LATENCY`)+1 cycles. With `READ_LATENCY`=1, `done` rises 5 cycles after `start`.
- **Registered outputs:** `id_ok`, `ts_ok` and `pass` are registered and become valid in the same cycle `done` rises.
- **Reset mid-check:** asserting `reset_n` low mid-check returns everything to reset values immediately (asynchronous). Auto-start then reruns the check if enabled.

## Configuration

Macro: `SYSID_CHECKER_TIMEOUT_EN`.

- **Defined:**
  - A 16-bit stall counter runs in RD_ID and RD_TS while `avm_waitrequest`=1, and resets on acceptance or state change.
  - When it reaches `TIMEOUT_CYCLES`: drop `avm_read`, set `timeout`=1, go to DONE. `id_ok`/`ts_ok` stay 0 for any word not captured.
- **Not defined:**
  - The counter logic is absent and `timeout` is tied to 0.
  - The block waits indefinitely on `avm_waitrequest`.

## Test plan

- **Auto-start pass:** slave returns `23176147`/`52052AC3`, zero wait, `READ_LATENCY`=1 → reads at address 0 then 1; `done`=`pass`=1 five cycles after reset release.
- **ID mismatch:** slave word 0 returns `00000001` → `done`=1, `id_ok`=0, `ts_ok`=1, `pass`=0, `id_value`=`00000001`.
- **Wait states:** `avm_waitrequest` held high 3 cycles on each read → `avm_read`/`avm_address` stable throughout; `done` rises 6 cycles later than the zero-wait case.
- **Start while busy:** pulse `start` during LAT_ID → ignored, exactly two reads issued. A `start` in DONE → status clears and a new check completes.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=10, waitrequest stuck high) → `timeout`=1 and `done`=1 with `avm_read` low after 10 stall cycles; `pass`=0.
- **Reset mid-check:** `reset_n` pulled low during RD_TS → all outputs 0 immediately; a full check reruns after release.
